alu_wb_arbiter: RTL

//  Parametrised write-back arbiter for the TPU backend ALU cluster.
//  - Collects results from NUM_CH execution sub-units (MA, iDiv, Cnvt, SRL, ...) through per-channel FIFOs.
//  - Each cycle, selects the oldest pending result by issue-number age and drives a single registered write-back port.
//  - Sits between the sub-unit outputs and the register-file write port; honours pipeline stall.

---
 rtl/alu_wb_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_wb_arbiter.sv
// Age-ordered write-back arbiter: per-channel result FIFOs feeding one registered WB port.
// Optional `ALU_WB_BYPASS_EN: an empty channel's incoming result may go straight to the WB register.

module alu_wb_arbiter_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 48
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by r_cnt alone.
  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rptr];
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
endmodule

module alu_wb_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int DEPTH       = 4,
  parameter int WIDTH_DATA  = 32,
  parameter int WIDTH_INDEX = 8,
  parameter int WIDTH_ISSUE = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [WIDTH_ISSUE-1:0]          I_Issue_No,
  input  logic                            I_Stall,
  input  logic [NUM_CH-1:0]               I_Valid,
  input  logic [NUM_CH*WIDTH_DATA-1:0]    I_Data,
  input  logic [NUM_CH*WIDTH_INDEX-1:0]   I_Index,
  input  logic [NUM_CH*WIDTH_ISSUE-1:0]   I_IssueNo,
  output logic [NUM_CH-1:0]               O_Ready,
  output logic                            O_WB_Valid,
  output logic [WIDTH_DATA-1:0]           O_WB_Data,
  output logic [WIDTH_INDEX-1:0]          O_WB_Index,
  output logic [WIDTH_ISSUE-1:0]          O_WB_IssueNo,
  output logic [$clog2(NUM_CH)-1:0]       O_WB_Ch,
  output logic                            O_Overflow
);
  localparam int EW  = WIDTH_DATA + WIDTH_INDEX + WIDTH_ISSUE;
  localparam int CHW = $clog2(NUM_CH);

  logic [NUM_CH-1:0][EW-1:0]          w_in, w_head_q, w_head;
  logic [NUM_CH-1:0][WIDTH_ISSUE-1:0] w_age;
  logic [NUM_CH-1:0]                  w_empty, w_full, w_push, w_pop, w_cand, w_byp;
  logic                               w_any, w_take;
  logic [CHW-1:0]                     w_win;
  logic [WIDTH_ISSUE-1:0]             w_best;
  logic [EW-1:0]                      w_sel;

  logic                   r_wb_valid, r_ovf;
  logic [WIDTH_DATA-1:0]  r_wb_data;
  logic [WIDTH_INDEX-1:0] r_wb_index;
  logic [WIDTH_ISSUE-1:0] r_wb_issue;
  logic [CHW-1:0]         r_wb_ch;

  assign w_take = w_any & ~I_Stall;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // Entry layout {data, index, issue}; issue sits in the LSBs for the age subtract.
    assign w_in[c] = {I_Data[c*WIDTH_DATA +: WIDTH_DATA],
                      I_Index[c*WIDTH_INDEX +: WIDTH_INDEX],
                      I_IssueNo[c*WIDTH_ISSUE +: WIDTH_ISSUE]};

`ifdef ALU_WB_BYPASS_EN
    assign w_cand[c] = ~w_empty[c] | I_Valid[c];
    assign w_head[c] = w_empty[c] ? w_in[c] : w_head_q[c];
`else
    assign w_cand[c] = ~w_empty[c];
    assign w_head[c] = w_head_q[c];
`endif

    assign w_age[c]  = I_Issue_No - w_head[c][WIDTH_ISSUE-1:0];
    assign w_byp[c]  = w_take & (w_win == CHW'(c)) & w_empty[c];
    assign w_pop[c]  = w_take & (w_win == CHW'(c)) & ~w_empty[c];
    assign w_push[c] = I_Valid[c] & ~w_full[c] & ~w_byp[c];

    alu_wb_arbiter_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (w_push[c]),
      .i_pop   (w_pop[c]),
      .i_din   (w_in[c]),
      .o_dout  (w_head_q[c]),
      .o_empty (w_empty[c]),
      .o_full  (w_full[c])
    );
  end

  // Strict '>' while scanning upward leaves ties with the lowest channel.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_best = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_cand[c] && (!w_any || w_age[c] > w_best)) begin
        w_any  = 1'b1;
        w_win  = CHW'(c);
        w_best = w_age[c];
      end
    end
  end

  assign w_sel = w_head[w_win];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
      r_wb_index <= '0;
      r_wb_issue <= '0;
      r_wb_ch    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_ovf <= r_ovf | (|(I_Valid & w_full));
      if (!I_Stall) begin
        r_wb_valid <= w_any;
        if (w_any) begin
          r_wb_data  <= w_sel[EW-1 -: WIDTH_DATA];
          r_wb_index <= w_sel[WIDTH_ISSUE +: WIDTH_INDEX];
          r_wb_issue <= w_sel[WIDTH_ISSUE-1:0];
          r_wb_ch    <= w_win;
        end
      end
    end
  end

  assign O_Ready      = ~w_full;
  assign O_WB_Valid   = r_wb_valid;
  assign O_WB_Data    = r_wb_data;
  assign O_WB_Index   = r_wb_index;
  assign O_WB_IssueNo = r_wb_issue;
  assign O_WB_Ch      = r_wb_ch;
  assign O_Overflow   = r_ovf;
endmodule
